// File: rtl/keyb_ps2.sv
// PS/2 keyboard receiver with byte FIFO and CPU register window.
// DATA pops on read, STATUS flags are W1C, CONTROL holds irq_en and flush.
module keyb_ps2 #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  logic          r_kc_s1, r_kc_s2, r_kc_d;
  logic          r_kd_s1, r_kd_s2;
  state_t        r_state, w_state_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic [15:0]   r_tmo, w_tmo_n;
  logic          r_push_pend;
  logic          w_fall, w_bit, w_push_req, w_frame_err;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [7:0]    r_last, r_dout;
  logic          r_ovf, r_perr, r_irq_en, r_irq;
  logic          w_rd, w_wr, w_pop, w_flush, w_push, w_full, w_wr_en;
  logic          w_ovf_set, w_w1c, w_ne;
  logic [4:0]    w_cnt_ext;
  logic [3:0]    w_cnt4;
  logic [7:0]    w_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kc_s1 <= 1'b1;
      r_kc_s2 <= 1'b1;
      r_kc_d  <= 1'b1;
      r_kd_s1 <= 1'b1;
      r_kd_s2 <= 1'b1;
    end else begin
      r_kc_s1 <= ps2_clk;
      r_kc_s2 <= r_kc_s1;
      r_kc_d  <= r_kc_s2;
      r_kd_s1 <= ps2_data;
      r_kd_s2 <= r_kd_s1;
    end
  end

  assign w_fall = r_kc_d & ~r_kc_s2;
  assign w_bit  = r_kd_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tmo       <= '0;
      r_push_pend <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bitcnt    <= w_bitcnt_n;
      r_shift     <= w_shift_n;
      r_par       <= w_par_n;
      r_tmo       <= w_tmo_n;
      r_push_pend <= w_push_req;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_bitcnt_n  = r_bitcnt;
    w_shift_n   = r_shift;
    w_par_n     = r_par;
    w_push_req  = 1'b0;
    w_frame_err = 1'b0;
    if (w_fall)
      w_tmo_n = '0;
    else if (r_state != IDLE)
      w_tmo_n = r_tmo + 16'd1;
    else
      w_tmo_n = '0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_n  = SHIFT;
          w_bitcnt_n = '0;
        end
      end
      SHIFT: begin
        if (w_fall) begin
          w_shift_n  = {w_bit, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7)
            w_state_n = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_n   = w_bit;
          w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_n = IDLE;
          if (w_bit && (^{r_shift, r_par}))
            w_push_req = 1'b1;
          else
            w_frame_err = 1'b1;
        end
      end
    endcase
    // a stalled partial frame is dropped silently
    if (r_state != IDLE && !w_fall && r_tmo >= TIMEOUT) begin
      w_state_n = IDLE;
      w_tmo_n   = '0;
    end
  end

  assign w_rd      = cs & ~we;
  assign w_wr      = cs & we;
  assign w_ne      = (r_count != '0);
  assign w_pop     = w_rd & (addr == 4'h0) & w_ne;
  assign w_flush   = w_wr & (addr == 4'h2) & data_in[7];
  assign w_w1c     = w_wr & (addr == 4'h1);
  assign w_push    = r_push_pend & ~w_flush;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wp] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_wr_en && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_wr_en && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf    <= 1'b0;
      r_perr   <= 1'b0;
      r_irq_en <= 1'b0;
      r_last   <= '0;
      r_dout   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set | (r_ovf & ~(w_w1c & data_in[1]));
      r_perr <= w_frame_err | (r_perr & ~(w_w1c & data_in[2]));
      if (w_wr && addr == 4'h2)
        r_irq_en <= data_in[0];
      if (w_pop)
        r_last <= r_mem[r_rp];
      if (w_rd)
        r_dout <= w_rdata;
      r_irq <= r_irq_en & (w_ne | r_ovf | r_perr);
    end
  end

  assign w_cnt_ext = 5'(r_count);
  assign w_cnt4    = (w_cnt_ext > 5'd15) ? 4'hF : w_cnt_ext[3:0];

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (addr == 4'h0): w_rdata = w_ne ? r_mem[r_rp] : r_last;
      (addr == 4'h1): w_rdata = {w_cnt4, 1'b0, r_perr, r_ovf, w_ne};
      (addr == 4'h2): w_rdata = {7'd0, r_irq_en};
      default:        w_rdata = '0;
    endcase
  end

  assign data_out = r_dout;
  assign irq      = r_irq;

endmodule

// File: tb/tb_keyb_ps2.sv
// Bench for keyb_ps2: PS/2 frames driven from tasks, bytes tracked in a
// scoreboard queue, STATUS predicted from a small flag model.
module tb_keyb_ps2;

  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd200;
  localparam int          H     = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  logic [7:0] m_last = 8'h00;
  logic       m_ovf  = 1'b0;
  logic       m_perr = 1'b0;
  logic [7:0] rd_val;

  keyb_ps2 #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .cs(cs), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %02h exp %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] st_exp();
    logic [3:0] c;
    c = (sb_q.size() > 15) ? 4'hF : 4'(sb_q.size());
    return {c, 1'b0, m_perr, m_ovf, sb_q.size() != 0};
  endfunction

  task automatic sb_push(input logic [7:0] b);
    if (sb_q.size() < DEPTH) sb_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    v = data_out;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd_status(input string tag);
    logic [7:0] v;
    bus_read(4'h1, v);
    chk(tag, v, st_exp());
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] v;
    bus_read(4'h0, v);
    if (sb_q.size() != 0) m_last = sb_q.pop_front();
    chk(tag, v, m_last);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // mode 1: DATA read lands in the push cycle; mode 2: check irq latency
  task automatic frame(input logic [7:0] b, input logic bad_par,
                       input int mode);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = 4'h0;
      @(negedge clk);
      cs = 1'b0;
      rd_val = data_out;
    end else if (mode == 2) begin
      repeat (4) @(negedge clk);
      chk("irq_pre", {7'd0, irq}, 8'h00);
      @(negedge clk);
      chk("irq_post", {7'd0, irq}, 8'h01);
    end
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rd_status("rst_status");

    frame(8'h1C, 1'b0, 0); sb_push(8'h1C);
    chk("f1_status_c", st_exp(), 8'h11);
    rd_status("f1_status");
    rd_data("f1_data");
    rd_status("f1_status2");

    frame(8'h1C, 1'b1, 0); m_perr = 1'b1;
    rd_status("par_status");
    bus_write(4'h1, 8'h04); m_perr = 1'b0;
    rd_status("par_clr");

    for (int i = 1; i <= 9; i++) begin
      frame(8'(i), 1'b0, 0);
      sb_push(8'(i));
    end
    rd_status("ovf_status");
    for (int i = 0; i < 8; i++) rd_data("ovf_data");
    rd_status("ovf_held");
    rd_data("empty_data");
    bus_write(4'h1, 8'h02); m_ovf = 1'b0;
    rd_status("ovf_clr");

    for (int i = 1; i <= 8; i++) begin
      frame(8'(i), 1'b0, 0);
      sb_push(8'(i));
    end
    frame(8'h09, 1'b0, 1);
    m_last = sb_q.pop_front();
    chk("full_pop", rd_val, m_last);
    sb_push(8'h09);
    rd_status("full_status");
    for (int i = 0; i < 8; i++) rd_data("full_drain");
    rd_status("full_empty");

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (int'(TMO) + 50) @(negedge clk);
    frame(8'hF0, 1'b0, 0); sb_push(8'hF0);
    rd_status("tmo_status");
    rd_data("tmo_data");

    bus_write(4'h2, 8'h01);
    bus_read(4'h2, rd_val);
    chk("ctrl_rd", rd_val, 8'h01);
    frame(8'hA5, 1'b0, 2); sb_push(8'hA5);
    rd_data("irq_data");
    @(negedge clk);
    chk("irq_clr", {7'd0, irq}, 8'h00);

    frame(8'h33, 1'b0, 0); sb_push(8'h33);
    rd_status("pre_rst_status");
    chk("pre_rst_irq", {7'd0, irq}, 8'h01);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_irq", {7'd0, irq}, 8'h00);
    reset = 1'b0;
    sb_q.delete();
    m_last = 8'h00;
    rd_status("post_rst_status");
    rd_data("post_rst_data");
    frame(8'h5A, 1'b0, 0); sb_push(8'h5A);
    rd_status("post_rst_f_status");
    rd_data("post_rst_f_data");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
